// File: rtl/dsc_cache_arbiter.sv
// Descriptor-cache RAM sequencer: zero-fill sweep, round-robin reads, tagged returns.
// Optional error counters (SB_CNT/DB_CNT) enabled by defining DSC_CACHE_ERRCNT_EN.
module dsc_cache_arbiter #(
  parameter int WIDTH  = 128,
  parameter int ADDR_W = 7,
  parameter int NUM_RQ = 4,
  parameter int RD_LAT = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic                     init_done_o,
  input  logic [NUM_RQ-1:0]        rd_req_i,
  input  logic [NUM_RQ*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RQ-1:0]        rd_gnt_o,
  output logic [NUM_RQ-1:0]        rd_valid_o,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     rd_err_o,
  input  logic                     wr_req_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic                     wr_ack_o,
  output logic                     ram_wen_o,
  output logic [ADDR_W-1:0]        ram_waddr_o,
  output logic [WIDTH-1:0]         ram_wdata_o,
  output logic                     ram_ren_o,
  output logic [ADDR_W-1:0]        ram_raddr_o,
  input  logic [WIDTH-1:0]         ram_rdata_i,
  input  logic                     ram_sb_correct_i,
  input  logic                     ram_db_detect_i
`ifdef DSC_CACHE_ERRCNT_EN
  ,
  output logic [15:0]              sb_cnt_o,
  output logic [15:0]              db_cnt_o
`endif
);

  localparam int PTR_W = (NUM_RQ > 1) ? $clog2(NUM_RQ) : 1;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t                         state_q, state_d;
  logic [ADDR_W-1:0]              cnt_q, cnt_d;
  logic                           init_done_q;
  logic [PTR_W-1:0]               ptr_q, ptr_d;
  logic [NUM_RQ-1:0]              gnt;
  logic [RD_LAT-1:0][NUM_RQ-1:0]  pipe_q;
  int                             idx;
  logic                           found;

  // Sweep/run sequencing and write-port steering.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_wen_o   = 1'b0;
    ram_waddr_o = '0;
    ram_wdata_o = '0;
    wr_ack_o    = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        INIT: begin
          ram_wen_o   = 1'b1;
          ram_waddr_o = cnt_q;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = RUN;
        end
        RUN: begin
          wr_ack_o    = wr_req_i;
          ram_wen_o   = wr_req_i;
          ram_waddr_o = wr_addr_i;
          ram_wdata_o = wr_data_i;
        end
        default: state_d = INIT;
      endcase
    end
  end

  // Round-robin read pick; a read colliding with this cycle's write waits.
  always_comb begin
    gnt         = '0;
    ptr_d       = ptr_q;
    ram_raddr_o = '0;
    found       = 1'b0;
    idx         = 0;
    if (!rst_i && state_q == RUN) begin
      for (int k = 0; k < NUM_RQ; k++) begin
        idx = (int'(ptr_q) + k) % NUM_RQ;
        if (!found && rd_req_i[idx] &&
            !(wr_req_i &&
              rd_addr_i[idx*ADDR_W +: ADDR_W] == wr_addr_i)) begin
          found       = 1'b1;
          gnt[idx]    = 1'b1;
          ram_raddr_o = rd_addr_i[idx*ADDR_W +: ADDR_W];
          ptr_d       = PTR_W'((idx + 1) % NUM_RQ);
        end
      end
    end
  end

  assign rd_gnt_o    = gnt;
  assign ram_ren_o   = found;
  assign init_done_o = init_done_q;

  // State, sweep counter, done flag and round-robin pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == RUN);
      ptr_q       <= ptr_d;
    end
  end

  // Return tag pipeline, aligned with the RAM read latency.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= gnt;
      for (int s = 1; s < RD_LAT; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign rd_valid_o = pipe_q[RD_LAT-1];
  assign rd_data_o  = ram_rdata_i;
  assign rd_err_o   = ram_db_detect_i & (|rd_valid_o);

`ifdef DSC_CACHE_ERRCNT_EN
  logic [15:0] sb_q, db_q;

  // Saturating error counters on returning words.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sb_q <= '0;
      db_q <= '0;
    end else if (|rd_valid_o) begin
      if (ram_sb_correct_i && sb_q != 16'hFFFF) sb_q <= sb_q + 16'd1;
      if (ram_db_detect_i && db_q != 16'hFFFF) db_q <= db_q + 16'd1;
    end
  end

  assign sb_cnt_o = sb_q;
  assign db_cnt_o = db_q;
`else
  logic unused_sb;
  assign unused_sb = ram_sb_correct_i;
`endif

endmodule

// File: tb/tb_dsc_cache_arbiter.sv
// Randomized bench for dsc_cache_arbiter with an in-bench RAM and reference model.
// Counter checks compiled in when DSC_CACHE_ERRCNT_EN is defined.
module tb_dsc_cache_arbiter;
  localparam int N = 4, AW = 7, W = 128, DEPTH = 128, LAT = 2;

  logic clk = 0, rst = 1;
  logic init_done;
  logic [N-1:0] rd_req = '0, rd_gnt, rd_valid;
  logic [AW-1:0] ra [N];
  logic [N*AW-1:0] rd_addr;
  logic [W-1:0] rd_data;
  logic rd_err;
  logic wr_req = 0, wr_ack;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic ram_wen, ram_ren;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [W-1:0] ram_wdata, ram_rdata;
  logic sb = 0, db = 0;
`ifdef DSC_CACHE_ERRCNT_EN
  logic [15:0] sb_cnt, db_cnt;
`endif

  assign rd_addr = {ra[3], ra[2], ra[1], ra[0]};

  always #5 clk = ~clk;

  dsc_cache_arbiter #(.WIDTH(W), .ADDR_W(AW), .NUM_RQ(N), .RD_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .init_done_o(init_done),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_err_o(rd_err),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_ack_o(wr_ack), .ram_wen_o(ram_wen), .ram_waddr_o(ram_waddr),
    .ram_wdata_o(ram_wdata), .ram_ren_o(ram_ren), .ram_raddr_o(ram_raddr),
    .ram_rdata_i(ram_rdata), .ram_sb_correct_i(sb), .ram_db_detect_i(db)
`ifdef DSC_CACHE_ERRCNT_EN
    , .sb_cnt_o(sb_cnt), .db_cnt_o(db_cnt)
`endif
  );

  // Environment RAM: one write port, registered read of latency LAT.
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rp [LAT];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    rp[0] <= mem[ram_raddr];
    for (int s = 1; s < LAT; s++) rp[s] <= rp[s-1];
  end
  assign ram_rdata = rp[LAT-1];

  int vecs = 0, errs = 0;

  task automatic chk(input string nm, input logic [W-1:0] a,
                     input logic [W-1:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Reference model state.
  typedef struct {
    int          due;
    logic [N-1:0] tag;
    logic [W-1:0] d;
  } ret_t;
  ret_t q[$];
  logic [W-1:0] mm [DEPTH];
  int cyc = 0, m_c = 0, m_ptr = 0, eidx, ii;
  bit run;
  logic [N-1:0] ev;
  logic [W-1:0] ed;
  ret_t r;
`ifdef DSC_CACHE_ERRCNT_EN
  int msb = 0, mdb = 0;
`endif

  // Per-cycle comparison against the model, then model advance.
  always @(negedge clk) begin
    if (rst) begin
      m_c = 0; m_ptr = 0; q.delete();
      chk("rst_gnt", rd_gnt, 0);
      chk("rst_valid", rd_valid, 0);
      chk("rst_done", init_done, 0);
      chk("rst_wen", ram_wen, 0);
      chk("rst_ren", ram_ren, 0);
      chk("rst_ack", wr_ack, 0);
`ifdef DSC_CACHE_ERRCNT_EN
      msb = 0; mdb = 0;
      chk("rst_sbcnt", sb_cnt, 0);
      chk("rst_dbcnt", db_cnt, 0);
`endif
    end else begin
      run = (m_c >= DEPTH);
      chk("init_done", init_done, run);
      eidx = -1;
      if (run) begin
        for (int k = 0; k < N; k++) begin
          ii = (m_ptr + k) % N;
          if (eidx < 0 && rd_req[ii] && !(wr_req && ra[ii] == wr_addr))
            eidx = ii;
        end
      end
      chk("gnt", rd_gnt, (eidx < 0) ? 0 : (1 << eidx));
      chk("ren", ram_ren, eidx >= 0);
      if (eidx >= 0) chk("raddr", ram_raddr, ra[eidx]);
      if (!run) begin
        chk("ack_init", wr_ack, 0);
        chk("wen_init", ram_wen, 1);
        chk("waddr_init", ram_waddr, m_c);
        chk("wdata_init", ram_wdata, 0);
      end else begin
        chk("ack", wr_ack, wr_req);
        chk("wen", ram_wen, wr_req);
        if (wr_req) begin
          chk("waddr", ram_waddr, wr_addr);
          chk("wdata", ram_wdata, wr_data);
        end
      end
      ev = '0; ed = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        r = q.pop_front();
        ev = r.tag; ed = r.d;
      end
      chk("valid", rd_valid, ev);
      if (ev != 0) chk("rdata", rd_data, ed);
      chk("rd_err", rd_err, db & (ev != 0));
`ifdef DSC_CACHE_ERRCNT_EN
      chk("sb_cnt", sb_cnt, msb);
      chk("db_cnt", db_cnt, mdb);
      if (ev != 0) begin
        if (sb && msb < 65535) msb++;
        if (db && mdb < 65535) mdb++;
      end
`endif
      if (eidx >= 0) begin
        r.due = cyc + LAT; r.tag = N'(1 << eidx); r.d = mm[ra[eidx]];
        q.push_back(r);
        m_ptr = (eidx + 1) % N;
      end
      if (!run) begin
        mm[m_c] = '0;
        m_c++;
      end else if (wr_req) begin
        mm[wr_addr] = wr_data;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rand_phase(input int n);
    logic [N-1:0] g;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      g = rd_gnt;
      step();
      for (int i = 0; i < N; i++) begin
        if (g[i]) rd_req[i] = 1'b0;
        else if (!rd_req[i] && $urandom_range(0, 2) == 0) begin
          rd_req[i] = 1'b1;
          ra[i] = AW'($urandom_range(0, 15));
        end
      end
      wr_req  = ($urandom_range(0, 2) == 0);
      wr_addr = AW'($urandom_range(0, 15));
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      sb = ($urandom_range(0, 3) == 0);
      db = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) ra[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    rd_req = 4'hF;
    for (int i = 0; i < N; i++) ra[i] = AW'(20 + i);
    repeat (127) step();
    @(negedge clk);
    chk("lit_done_lo", init_done, 0);
    chk("lit_nogrant_init", rd_gnt, 0);
    step();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) chk("lit_done_hi", init_done, 1);
      chk("lit_rr", rd_gnt, 4'b0001 << (k % 4));
      if (k >= 2) chk("lit_rr_valid", rd_valid, 4'b0001 << ((k - 2) % 4));
      step();
    end
    rd_req = '0;
    repeat (3) step();

    wr_req = 1; wr_addr = 7'd5; wr_data = {16{8'hA5}};
    @(negedge clk);
    chk("lit_wack", wr_ack, 1);
    step();
    wr_req = 0; rd_req = 4'b0100; ra[2] = 7'd5;
    @(negedge clk);
    chk("lit_gnt2", rd_gnt, 4'b0100);
    step();
    rd_req = '0;
    step();
    @(negedge clk);
    chk("lit_val2", rd_valid, 4'b0100);
    chk("lit_data2", rd_data, {16{8'hA5}});
    step();

    wr_req = 1; wr_addr = 7'd9; wr_data = {16{8'h3C}};
    rd_req = 4'b0010; ra[1] = 7'd9;
    @(negedge clk);
    chk("lit_haz_ack", wr_ack, 1);
    chk("lit_haz_gnt", rd_gnt, 0);
    step();
    wr_req = 0;
    @(negedge clk);
    chk("lit_gnt1", rd_gnt, 4'b0010);
    step();
    rd_req = '0;
    step();
    @(negedge clk);
    chk("lit_val1", rd_valid, 4'b0010);
    chk("lit_data1", rd_data, {16{8'h3C}});
    step();

    rand_phase(2500);

    wr_req = 0; rd_req = 4'b0011; ra[0] = 7'd1; ra[1] = 7'd2;
    repeat (2) step();
    rst = 1; rd_req = '0;
    @(negedge clk);
    chk("lit_rst_valid", rd_valid, 0);
    chk("lit_rst_done", init_done, 0);
    step();
    #1 rst = 0;
    rd_req = 4'hF;
    @(negedge clk);
    chk("lit_reinit_valid", rd_valid, 0);
    chk("lit_reinit_wen", ram_wen, 1);
    chk("lit_reinit_waddr", ram_waddr, 0);
    chk("lit_reinit_done", init_done, 0);
    repeat (130) step();
    rd_req = '0;
    rand_phase(500);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
